// File: rtl/elevator_dispatcher_if.sv
// Call/step/target bundle between the call front end, the dispatcher and the car controller.
// The dispatcher sits on the master side; the controller and front end sit on the slave side.
interface elevator_dispatcher_if;
   localparam int unsigned FLOORS  = 16;
   localparam int unsigned FLOOR_W = 4;

   logic [FLOORS-1:0]  call;
   logic               up;
   logic               dwn;
   logic               complete;
   logic [FLOOR_W-1:0] req;
   logic [FLOORS-1:0]  pending;
   logic [FLOOR_W-1:0] pos;
   logic               dir_up;
   logic               busy;
   logic               served;
   logic [FLOOR_W-1:0] served_floor;
   logic               fault;

   modport master (
      input  call, up, dwn, complete,
      output req, pending, pos, dir_up, busy, served, served_floor, fault
   );

   modport slave (
      output call, up, dwn, complete,
      input  req, pending, pos, dir_up, busy, served, served_floor, fault
   );
endinterface

// File: rtl/elevator_dispatcher.sv
// SCAN call dispatcher for a single-car elevator: latches calls, tracks the car,
// issues one target at a time to the controller and clears the call on arrival.
module elevator_dispatcher #(
   parameter int unsigned DOOR_CYC   = 20,
   parameter int unsigned TRAVEL_MAX = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   elevator_dispatcher_if.master bus
);

   localparam int unsigned FLOORS  = 16;
   localparam int unsigned FLOOR_W = 4;
   localparam int unsigned CNT_MAX = (DOOR_CYC > TRAVEL_MAX) ? DOOR_CYC : TRAVEL_MAX;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_TRAVEL,
      S_DOOR
   } state_t;

   state_t             r_state;
   logic [FLOOR_W-1:0] r_req;
   logic [FLOORS-1:0]  r_pending;
   logic [FLOOR_W-1:0] r_pos;
   logic               r_dir_up;
   logic               r_busy;
   logic               r_served;
   logic [FLOOR_W-1:0] r_served_floor;
   logic               r_fault;
   logic [CNT_W-1:0]   r_cnt;

   state_t             w_state_nxt;
   logic [FLOOR_W-1:0] w_req_nxt;
   logic [FLOORS-1:0]  w_pending_nxt;
   logic [FLOOR_W-1:0] w_pos_nxt;
   logic               w_dir_nxt;
   logic               w_busy_nxt;
   logic               w_served_nxt;
   logic [FLOOR_W-1:0] w_sfloor_nxt;
   logic               w_fault_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;

   logic               w_above_vld;
   logic [FLOOR_W-1:0] w_above;
   logic               w_below_vld;
   logic [FLOOR_W-1:0] w_below;
   logic [FLOOR_W-1:0] w_tgt;
   logic               w_tgt_dir;
   logic               w_arrive;
   logic [FLOORS-1:0]  w_req_oh;
   logic [FLOORS-1:0]  w_tgt_oh;

   // Nearest pending floor on each side of the car, then the SCAN choice.
   always_comb begin
      w_above_vld = 1'b0;
      w_above     = '0;
      w_below_vld = 1'b0;
      w_below     = '0;
      for (int i = FLOORS - 1; i >= 0; i--) begin
         if (r_pending[i] && (FLOOR_W'(i) > r_pos)) begin
            w_above_vld = 1'b1;
            w_above     = FLOOR_W'(i);
         end
      end
      for (int i = 0; i < FLOORS; i++) begin
         if (r_pending[i] && (FLOOR_W'(i) < r_pos)) begin
            w_below_vld = 1'b1;
            w_below     = FLOOR_W'(i);
         end
      end

      w_tgt     = r_pos;
      w_tgt_dir = r_dir_up;
      if (r_pending[r_pos]) begin
         w_tgt = r_pos;
      end else if (r_dir_up) begin
         if (w_above_vld) begin
            w_tgt = w_above;
         end else begin
            w_tgt     = w_below;
            w_tgt_dir = 1'b0;
         end
      end else begin
         if (w_below_vld) begin
            w_tgt = w_below;
         end else begin
            w_tgt     = w_above;
            w_tgt_dir = 1'b1;
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_req_nxt     = r_req;
      w_pending_nxt = r_pending | bus.call;
      w_pos_nxt     = r_pos;
      w_dir_nxt     = r_dir_up;
      w_served_nxt  = 1'b0;
      w_sfloor_nxt  = r_served_floor;
      w_fault_nxt   = r_fault;
      w_cnt_nxt     = r_cnt;
      w_req_oh      = FLOORS'(1) << r_req;
      w_tgt_oh      = FLOORS'(1) << w_tgt;
      w_arrive      = bus.complete && !bus.up && !bus.dwn && (r_pos == r_req);

      // Simultaneous up and dwn is treated as no step.
      if (bus.up && !bus.dwn && (r_pos != FLOOR_W'(FLOORS - 1))) begin
         w_pos_nxt = r_pos + FLOOR_W'(1);
      end else if (bus.dwn && !bus.up && (r_pos != '0)) begin
         w_pos_nxt = r_pos - FLOOR_W'(1);
      end

      case (r_state)
         S_IDLE: begin
            if (r_pending != '0) begin
               w_req_nxt = w_tgt;
               w_dir_nxt = w_tgt_dir;
               w_cnt_nxt = '0;
               if (w_tgt == r_pos) begin
                  w_state_nxt   = S_DOOR;
                  w_pending_nxt = (r_pending | bus.call) & ~w_tgt_oh;
                  w_served_nxt  = 1'b1;
                  w_sfloor_nxt  = w_tgt;
               end else begin
                  w_state_nxt = S_TRAVEL;
               end
            end
         end

         S_TRAVEL: begin
            if (w_arrive) begin
               w_state_nxt   = S_DOOR;
               w_pending_nxt = (r_pending | bus.call) & ~w_req_oh;
               w_served_nxt  = 1'b1;
               w_sfloor_nxt  = r_req;
               w_cnt_nxt     = '0;
            end else if (r_cnt == CNT_W'(TRAVEL_MAX - 1)) begin
               w_state_nxt = S_IDLE;
               w_fault_nxt = 1'b1;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         S_DOOR: begin
            // A call for the floor being served is already satisfied by the open door.
            w_pending_nxt = r_pending | (bus.call & ~w_req_oh);
            if (r_cnt == CNT_W'(DOOR_CYC - 1)) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_req          <= '0;
         r_pending      <= '0;
         r_pos          <= '0;
         r_dir_up       <= 1'b1;
         r_busy         <= 1'b0;
         r_served       <= 1'b0;
         r_served_floor <= '0;
         r_fault        <= 1'b0;
         r_cnt          <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_req          <= w_req_nxt;
         r_pending      <= w_pending_nxt;
         r_pos          <= w_pos_nxt;
         r_dir_up       <= w_dir_nxt;
         r_busy         <= w_busy_nxt;
         r_served       <= w_served_nxt;
         r_served_floor <= w_sfloor_nxt;
         r_fault        <= w_fault_nxt;
         r_cnt          <= w_cnt_nxt;
      end
   end

   assign bus.req          = r_req;
   assign bus.pending      = r_pending;
   assign bus.pos          = r_pos;
   assign bus.dir_up       = r_dir_up;
   assign bus.busy         = r_busy;
   assign bus.served       = r_served;
   assign bus.served_floor = r_served_floor;
   assign bus.fault        = r_fault;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Bench for elevator_dispatcher: a stepping car-controller model, directed corner
// sequences, a table of SCAN batches and random batches against a list-based SCAN model.
module tb_elevator_dispatcher;

   localparam int unsigned DOOR_CYC   = 20;
   localparam int unsigned TRAVEL_MAX = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   ignore = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   up_cnt  = 0;
   int   dwn_cnt = 0;
   logic [3:0] ctl_floor;

   int   exp_q[$];
   int   mdl_pos;
   bit   mdl_dir;

   typedef struct {
      logic [3:0]  start;
      logic [15:0] mask;
      logic [3:0]  first;
      logic [3:0]  last;
      logic        dir;
      int          count;
   } vec_t;

   vec_t vecs[6];

   elevator_dispatcher_if u_if ();

   elevator_dispatcher #(
      .DOOR_CYC  (DOOR_CYC),
      .TRAVEL_MAX(TRAVEL_MAX)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(u_if.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Car controller: steps one floor per cycle toward req, raises complete when there.
   initial begin
      u_if.up       = 1'b0;
      u_if.dwn      = 1'b0;
      u_if.complete = 1'b0;
      ctl_floor     = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            ctl_floor     = '0;
            u_if.up       = 1'b0;
            u_if.dwn      = 1'b0;
            u_if.complete = 1'b0;
         end else begin
            if (u_if.up) ctl_floor = ctl_floor + 4'd1;
            else if (u_if.dwn) ctl_floor = ctl_floor - 4'd1;
            if (ignore) begin
               u_if.up = 1'b0; u_if.dwn = 1'b0; u_if.complete = 1'b0;
            end else if (u_if.req > ctl_floor) begin
               u_if.up = 1'b1; u_if.dwn = 1'b0; u_if.complete = 1'b0;
            end else if (u_if.req < ctl_floor) begin
               u_if.up = 1'b0; u_if.dwn = 1'b1; u_if.complete = 1'b0;
            end else begin
               u_if.up = 1'b0; u_if.dwn = 1'b0; u_if.complete = 1'b1;
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      if (rst && u_if.up) up_cnt++;
      if (rst && u_if.dwn) dwn_cnt++;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   // First pending floor found walking from 'from' in steps of 'step', or -1.
   function automatic int nearest(input logic [15:0] m, input int from, input int step);
      for (int f = from + step; f >= 0 && f < 16; f += step)
         if (m[f]) return f;
      return -1;
   endfunction

   // Service order for a batch of calls issued to an idle car.
   function automatic void scan_model(input logic [15:0] mask);
      logic [15:0] m;
      int t;
      m = mask;
      exp_q.delete();
      while (m != 16'h0) begin
         if (m[mdl_pos]) begin
            t = mdl_pos;
         end else begin
            t = nearest(m, mdl_pos, mdl_dir ? 1 : -1);
            if (t < 0) begin
               t = nearest(m, mdl_pos, mdl_dir ? -1 : 1);
               mdl_dir = ~mdl_dir;
            end
         end
         exp_q.push_back(t);
         m[t]    = 1'b0;
         mdl_pos = t;
      end
   endfunction

   task automatic do_reset();
      u_if.call = '0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse(input logic [15:0] mask);
      u_if.call = mask;
      @(negedge clk);
      u_if.call = '0;
   endtask

   task automatic wait_served(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (u_if.served) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic serve_one(input int floor);
      bit ok;
      pulse(16'(1 << floor));
      wait_served(ok);
      check("serve_one_timeout", 32'(ok), 32'd1);
      check("serve_one_floor", 32'(u_if.served_floor), 32'(floor));
      repeat (DOOR_CYC + 2) @(negedge clk);
   endtask

   initial begin
      bit         ok;
      int         busy_cnt, srv_cnt, sf;
      logic [3:0] first, last;
      logic [15:0] mask;

      vecs[0] = '{4'd5,  16'h0284, 4'd7,  4'd2,  1'b0, 3};
      vecs[1] = '{4'd8,  16'h000A, 4'd3,  4'd1,  1'b0, 2};
      vecs[2] = '{4'd10, 16'h1410, 4'd10, 4'd4,  1'b0, 3};
      vecs[3] = '{4'd0,  16'h8000, 4'd15, 4'd15, 1'b1, 1};
      vecs[4] = '{4'd15, 16'h4001, 4'd14, 4'd0,  1'b0, 2};
      vecs[5] = '{4'd6,  16'h0080, 4'd7,  4'd7,  1'b1, 1};

      // Reset values with calls asserted during reset
      u_if.call = 16'hFFFF;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req", 32'(u_if.req), 32'd0);
      check("rst_pending", 32'(u_if.pending), 32'd0);
      check("rst_pos", 32'(u_if.pos), 32'd0);
      check("rst_dir_up", 32'(u_if.dir_up), 32'd1);
      check("rst_busy", 32'(u_if.busy), 32'd0);
      check("rst_served", 32'(u_if.served), 32'd0);
      check("rst_served_floor", 32'(u_if.served_floor), 32'd0);
      check("rst_fault", 32'(u_if.fault), 32'd0);
      #2 rst = 1'b1;
      @(negedge clk);
      check("rst_release_latch", 32'(u_if.pending), 32'hFFFF);
      u_if.call = '0;

      // Single call from floor 0 to floor 5
      do_reset();
      up_cnt = 0; busy_cnt = 0; srv_cnt = 0; sf = -1;
      pulse(16'h0020);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (u_if.busy) busy_cnt++;
         if (u_if.served) begin srv_cnt++; sf = 32'(u_if.served_floor); end
      end
      check("single_busy_cycles", 32'(busy_cnt), 32'(5 + 1 + DOOR_CYC));
      check("single_up_steps", 32'(up_cnt), 32'd5);
      check("single_served_cnt", 32'(srv_cnt), 32'd1);
      check("single_served_floor", 32'(sf), 32'd5);
      check("single_pos", 32'(u_if.pos), 32'd5);
      check("single_req", 32'(u_if.req), 32'd5);

      // Move to 3, then call the current floor while idle
      serve_one(3);
      check("down_dir", 32'(u_if.dir_up), 32'd0);
      up_cnt = 0; dwn_cnt = 0;
      pulse(16'h0008);
      @(negedge clk);
      check("cur_served", 32'(u_if.served), 32'd1);
      check("cur_served_floor", 32'(u_if.served_floor), 32'd3);
      check("cur_req", 32'(u_if.req), 32'd3);
      check("cur_busy", 32'(u_if.busy), 32'd1);
      // Re-call of the open-door floor is dropped
      pulse(16'h0008);
      check("door_mask_pending", 32'(u_if.pending), 32'd0);
      srv_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (u_if.served) srv_cnt++;
      end
      check("door_mask_no_reserve", 32'(srv_cnt), 32'd0);
      check("cur_no_steps", 32'(up_cnt + dwn_cnt), 32'd0);

      // Repeat call during travel is served once
      pulse(16'h0200);
      repeat (3) @(negedge clk);
      pulse(16'h0200);
      srv_cnt = 0; sf = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (u_if.served) begin srv_cnt++; sf = 32'(u_if.served_floor); end
      end
      check("travel_recall_cnt", 32'(srv_cnt), 32'd1);
      check("travel_recall_floor", 32'(sf), 32'd9);
      check("travel_recall_pending", 32'(u_if.pending), 32'd0);
      check("travel_recall_pos", 32'(u_if.pos), 32'd9);

      // Table of SCAN batches
      for (int v = 0; v < 6; v++) begin
         do_reset();
         if (vecs[v].start != 4'd0) serve_one(int'(vecs[v].start));
         pulse(vecs[v].mask);
         srv_cnt = 0; first = '0; last = '0;
         for (int k = 0; k < vecs[v].count; k++) begin
            wait_served(ok);
            check("vec_timeout", 32'(ok), 32'd1);
            if (!ok) break;
            srv_cnt++;
            if (k == 0) first = u_if.served_floor;
            last = u_if.served_floor;
         end
         repeat (DOOR_CYC + 2) @(negedge clk);
         check("vec_first", 32'(first), 32'(vecs[v].first));
         check("vec_last", 32'(last), 32'(vecs[v].last));
         check("vec_dir", 32'(u_if.dir_up), 32'(vecs[v].dir));
         check("vec_count", 32'(srv_cnt), 32'(vecs[v].count));
         check("vec_pos", 32'(u_if.pos), 32'(vecs[v].last));
         check("vec_pending", 32'(u_if.pending), 32'd0);
      end

      // Random batches against the SCAN model
      do_reset();
      mdl_pos = 0;
      mdl_dir = 1'b1;
      for (int b = 0; b < 20; b++) begin
         mask = 16'($urandom) & 16'($urandom);
         if (b % 5 == 0) mask = mask | 16'(1 << mdl_pos);
         if (mask == 16'h0) mask = 16'(1 << $urandom_range(0, 15));
         scan_model(mask);
         pulse(mask);
         foreach (exp_q[i]) begin
            wait_served(ok);
            check("rand_timeout", 32'(ok), 32'd1);
            if (!ok) break;
            check("rand_floor", 32'(u_if.served_floor), 32'(exp_q[i]));
         end
         repeat (DOOR_CYC + 2) @(negedge clk);
         check("rand_pos", 32'(u_if.pos), 32'(mdl_pos));
         check("rand_dir", 32'(u_if.dir_up), 32'(mdl_dir));
         check("rand_pending", 32'(u_if.pending), 32'd0);
         check("rand_busy", 32'(u_if.busy), 32'd0);
      end

      // Watchdog: controller never moves
      do_reset();
      ignore = 1'b1;
      busy_cnt = 0;
      pulse(16'h0010);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (u_if.fault) break;
         if (u_if.busy) busy_cnt++;
      end
      check("wd_fault", 32'(u_if.fault), 32'd1);
      check("wd_travel_cycles", 32'(busy_cnt), 32'(TRAVEL_MAX));
      check("wd_idle", 32'(u_if.busy), 32'd0);
      check("wd_pending_kept", 32'(u_if.pending), 32'h0010);
      ignore = 1'b0;
      repeat (3) @(negedge clk);
      check("wd_redispatch_moving", 32'(u_if.pos != 4'd0), 32'd1);
      check("wd_fault_sticky", 32'(u_if.fault), 32'd1);
      // Asynchronous reset mid-travel
      #2 rst = 1'b0;
      #1;
      check("async_rst_pos", 32'(u_if.pos), 32'd0);
      check("async_rst_req", 32'(u_if.req), 32'd0);
      check("async_rst_fault", 32'(u_if.fault), 32'd0);
      check("async_rst_pending", 32'(u_if.pending), 32'd0);
      check("async_rst_busy", 32'(u_if.busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/elevator_dispatcher.md
# elevator_dispatcher

Call-button dispatcher for the single-car elevator controller. It latches floor-call pulses into a pending set and picks the next target floor with a SCAN (direction-preferring) policy. It drives the controller's 4-bit `req` target, tracks car position from the controller's `up`/`dwn` step outputs, and clears a call once the controller reports `complete` at that floor. It sits between the call-button front end and the elevator controller, on the requesting side of the `req`/`complete` interface.

## Interface
- `DOOR_CYC`, default 20: cycles the car dwells at a served floor before the next dispatch.
- `TRAVEL_MAX`, default 64: watchdog limit, in cycles, spent in TRAVEL before a fault is raised.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset. One clock; reset is asynchronous and active-low.
- `call` input 16: per-floor call pulses; bit i requests floor i.
- `up` input 1: controller step-up indication. One floor per cycle while high.
- `dwn` input 1: controller step-down indication. One floor per cycle while high.
- `complete` input 1: controller at-target indication.
- `req` output 4: target floor sent to the controller.
- `pending` output 16: latched outstanding calls.
- `pos` output 4: tracked car floor.
- `dir_up` output 1: current sweep direction (1 = up).
- `busy` output 1: high in any state other than IDLE.
- `served` output 1: one-cycle pulse when a call is cleared.
- `served_floor` output 4: floor of the last cleared call.
- `fault` output 1: sticky watchdog flag.

## Operation
- Reset values: `req`=0, `pending`=0, `pos`=0, `dir_up`=1, `busy`=0, `served`=0, `served_floor`=0, `fault`=0, state IDLE, counters 0.
- Call latching, every cycle: `pending` |= `call`. Exception: in DOOR, `call` bits equal to `req` are masked. The arrival clear takes priority over a same-cycle set of that bit.
- Position: `pos`+1 on cycles with `up`=1; `pos`−1 on cycles with `dwn`=1. Both high together is illegal; `pos` holds. No wrap: increment at 15 and decrement at 0 saturate.
- Target selection, combinational, from `pending`, `pos` and `dir_up`:
  - `pending[pos]` set → target = `pos`.
  - Else if `dir_up`=1: lowest set bit above `pos`. If none, highest set bit below `pos`, and `dir_up` flips to 0.
  - Else: highest set bit below `pos`. If none, lowest set bit above `pos`, and `dir_up` flips to 1.
- States:
  - IDLE: if `pending`≠0, register the target into `req` and update `dir_up`. Go to DOOR if target = `pos`, else to TRAVEL.
  - TRAVEL: `req` is frozen; no retargeting. Arrival = `complete`=1 ∧ `up`=0 ∧ `dwn`=0 ∧ `pos`=`req`. On arrival go to DOOR. If the travel counter reaches `TRAVEL_MAX` first, set `fault`, keep `pending`, and go to IDLE.
  - DOOR: on entry, clear `pending[req]`, pulse `served`, and load `served_floor`=`req`. Stay `DOOR_CYC` cycles, then go to IDLE.
- `complete` is high from the previous service when `req` changes. The `pos`=`req` and step-low terms block a false arrival on the first TRAVEL cycle.
- `fault` clears only on reset. Dispatch continues after a fault.

## Timing
- A call pulse sampled at edge N → `pending` bit set after N.
- IDLE → `req` valid after edge N+1. The controller starts stepping after N+2.
- Travel of d floors: `up`/`dwn` high for d cycles. Arrival is then seen on the cycle `complete` rises, about d+2 cycles after `req` changes.
- `served` is high for exactly the first DOOR cycle.
- DOOR lasts exactly `DOOR_CYC` cycles. The next `req` can change on the edge leaving DOOR, through IDLE: one idle cycle between services.
- Call to the current floor while IDLE: DOOR is entered the next edge, with no `req` travel.
- Reset asserted mid-TRAVEL: all state returns to reset values immediately and asynchronously. The controller must be reset together with the dispatcher so that `pos` and the controller floor stay consistent.

## Test plan
- Reset: hold `rst`=0, pulse `call`=16'hFFFF → all outputs at reset values. Release → `pending`=FFFF after the first edge.
- Single call: from floor 0, `call[5]` → `req`=5, `up` high 5 cycles, `pos`=5, `served` pulse with `served_floor`=5, `busy` high for the travel plus 20 DOOR cycles.
- SCAN order: car at 5, `dir_up`=1, pending {2,7,9} → served order 7, 9, 2, with `dir_up`→0 when 2 is dispatched.
- Current floor: idle at 3, `call[3]` → DOOR next cycle, `req`=3, `served` pulse, no `up`/`dwn`.
- Masking: `call[req]` pulsed in DOOR → not re-latched. `call[req]` pulsed during TRAVEL → cleared on arrival, served once.
- Watchdog: controller model ignores `req` → `fault`=1 after 64 TRAVEL cycles, state IDLE, `pending` bit retained. Then `rst` mid-travel → `pos`=0, `req`=0.
